// File: rtl/shift_arbiter.sv
// Round-robin front-end for the shared 32-bit barrel shifter: two requesters,
// one grant per cycle, single-entry response register with backpressure.
//
// state | meaning
// EMPTY | response register holds nothing, rsp_valid = 0
// FULL  | response register holds a result, rsp_valid = 1
module shift_arbiter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [1:0]         req0_op,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [1:0]         req1_op,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic [1:0]         sh_op,
    output logic [DATA_W-1:0]  sh_T,
    output logic [SHAMT_W-1:0] sh_shamt,
    input  logic [DATA_W-1:0]  sh_Y,
    input  logic [3:0]         sh_flags,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [3:0]         rsp_flags,
    output logic               rsp_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    logic   last_grant;
    logic   can_accept;
    logic   gnt_any;
    logic   gnt_idx;
    logic   flags_v_unused;

    // The shifter's overflow flag has no meaning for shifts; it is dropped.
    assign flags_v_unused = sh_flags[2];

    assign can_accept = (state == EMPTY) || rsp_ready;
    assign rsp_valid  = (state == FULL);

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 1'b0;
        if (can_accept && reset_n) begin
            if (req0_valid && req1_valid) begin
                gnt_any = 1'b1;
                gnt_idx = ~last_grant;
            end else if (req0_valid) begin
                gnt_any = 1'b1;
                gnt_idx = 1'b0;
            end else if (req1_valid) begin
                gnt_any = 1'b1;
                gnt_idx = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_any && !gnt_idx;
    assign req1_ready = gnt_any && gnt_idx;

    always_comb begin
        sh_op    = '0;
        sh_T     = '0;
        sh_shamt = '0;
        if (gnt_any) begin
            if (gnt_idx) begin
                sh_op    = req1_op;
                sh_T     = req1_data;
                sh_shamt = req1_shamt;
            end else begin
                sh_op    = req0_op;
                sh_T     = req0_data;
                sh_shamt = req0_shamt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (gnt_any) begin
                state      <= FULL;
                last_grant <= gnt_idx;
                rsp_id     <= gnt_idx;
                rsp_data   <= sh_Y;
                rsp_flags  <= {sh_flags[3], 1'b0, sh_flags[1:0]};
                rsp_err    <= (sh_op == 2'b11);
            end else if ((state == FULL) && rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vector table followed by randomized
// traffic checked against a transaction-level reference model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  sh_op;
    logic [31:0] sh_T;
    logic [4:0]  sh_shamt;
    logic [31:0] sh_Y;
    logic [3:0]  sh_flags;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_shamt(req1_shamt),
        .sh_op(sh_op), .sh_T(sh_T), .sh_shamt(sh_shamt),
        .sh_Y(sh_Y), .sh_flags(sh_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    // Shared shifter stand-in; it always raises V so masking is visible.
    logic sh_c;
    int   sh_i;
    always_comb begin
        sh_c = 1'b0;
        sh_i = 0;
        sh_Y = sh_T;
        case (sh_op)
            2'b00: begin
                sh_Y = sh_T << sh_shamt;
                sh_i = 32 - int'(sh_shamt);
                if (sh_shamt != 0) sh_c = sh_T[sh_i];
            end
            2'b01: begin
                sh_Y = sh_T >> sh_shamt;
                sh_i = int'(sh_shamt) - 1;
                if (sh_shamt != 0) sh_c = sh_T[sh_i];
            end
            2'b10: begin
                sh_Y = $signed(sh_T) >>> sh_shamt;
                sh_i = int'(sh_shamt) - 1;
                if (sh_shamt != 0) sh_c = sh_T[sh_i];
            end
            default: sh_Y = sh_T;
        endcase
        sh_flags = {sh_c, 1'b1, sh_Y[31], (sh_Y == 32'd0)};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Expected {flags, data} computed with widened arithmetic: the carry is
    // the bit that falls just off the end of the word.
    function automatic logic [35:0] ref_rsp(input logic [1:0] op, input logic [31:0] t,
                                            input logic [4:0] s);
        logic [32:0]        w;
        logic signed [32:0] ws;
        logic [31:0]        d;
        logic               c;
        case (op)
            2'd0: begin w = {1'b0, t} << s; d = w[31:0]; c = w[32]; end
            2'd1: begin w = {t, 1'b0} >> s; d = w[32:1]; c = w[0]; end
            2'd2: begin ws = $signed({t, 1'b0}) >>> s; d = ws[32:1]; c = ws[0]; end
            default: begin d = t; c = 1'b0; end
        endcase
        return {c, 1'b0, d[31], (d == 32'd0), d};
    endfunction

    typedef struct {
        bit          rst, rr, v0, v1;
        logic [1:0]  op0, op1;
        logic [31:0] d0, d1;
        logic [4:0]  s0, s1;
        bit          e_r0, e_r1, e_v, e_id;
        logic [31:0] e_data;
        logic [3:0]  e_flags;
        bit          e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit rr,
                                bit v0, logic [1:0] op0, logic [31:0] d0, logic [4:0] s0,
                                bit v1, logic [1:0] op1, logic [31:0] d1, logic [4:0] s1,
                                bit er0, bit er1, bit ev, bit eid,
                                logic [31:0] edata, logic [3:0] eflags, bit eerr);
        vec_t v;
        v.rst = rst; v.rr = rr;
        v.v0 = v0; v.op0 = op0; v.d0 = d0; v.s0 = s0;
        v.v1 = v1; v.op1 = op1; v.d1 = d1; v.s1 = s1;
        v.e_r0 = er0; v.e_r1 = er1; v.e_v = ev; v.e_id = eid;
        v.e_data = edata; v.e_flags = eflags; v.e_err = eerr;
        return v;
    endfunction

    // Reference model state
    bit          m_full, m_id, m_err, m_turn;
    logic [31:0] m_data;
    logic [3:0]  m_flags;
    bit          pend[2];
    logic [1:0]  p_op[2];
    logic [31:0] p_d[2];
    logic [4:0]  p_s[2];

    initial begin
        bit          do_rst, eg_any, eg_idx;
        logic [35:0] r;
        logic [1:0]  e_op;
        logic [31:0] e_t;
        logic [4:0]  e_s;

        reset_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_data = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_op = '0; req1_data = '0; req1_shamt = '0;

        //          rst rr  v0 op0 d0            s0  v1 op1 d1       s1  r0 r1 v id data          flags    err
        tbl.push_back(mk(1, 0, 0, 0, 0,            0,  0, 0, 0,       0,  0, 0, 0, 0, 0,            4'b0000, 0));
        tbl.push_back(mk(0, 1, 1, 2, 32'h80000000, 4,  0, 0, 0,       0,  1, 0, 0, 0, 0,            4'b0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0,  0, 0, 0,       0,  0, 0, 1, 0, 32'hF8000000, 4'b0010, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0,  0, 0, 0,       0,  0, 0, 0, 0, 32'hF8000000, 4'b0010, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,            0,  0, 0, 0,       0,  0, 0, 0, 0, 0,            4'b0000, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h1,        1,  1, 1, 32'h10,  4,  1, 0, 0, 0, 0,            4'b0000, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h1,        1,  1, 1, 32'h10,  4,  0, 1, 1, 0, 32'h2,        4'b0000, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h1,        1,  1, 1, 32'h10,  4,  1, 0, 1, 1, 32'h1,        4'b0000, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h1,        1,  1, 1, 32'h10,  4,  0, 1, 1, 0, 32'h2,        4'b0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0,  0, 0, 0,       0,  0, 0, 1, 1, 32'h1,        4'b0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0,  0, 0, 0,       0,  0, 0, 0, 1, 32'h1,        4'b0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0,  1, 0, 32'h1,   31, 0, 1, 0, 1, 32'h1,        4'b0000, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'hF8,       4,  0, 0, 0,       0,  0, 0, 1, 1, 32'h80000000, 4'b0010, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'hF8,       4,  0, 0, 0,       0,  0, 0, 1, 1, 32'h80000000, 4'b0010, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'hF8,       4,  0, 0, 0,       0,  0, 0, 1, 1, 32'h80000000, 4'b0010, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'hF8,       4,  0, 0, 0,       0,  1, 0, 1, 1, 32'h80000000, 4'b0010, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0,  0, 0, 0,       0,  0, 0, 1, 0, 32'hF,        4'b1000, 0));
        tbl.push_back(mk(0, 1, 1, 3, 32'h1234,     0,  0, 0, 0,       0,  1, 0, 0, 0, 32'hF,        4'b1000, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h3,        2,  0, 0, 0,       0,  1, 0, 1, 0, 32'h1234,     4'b0000, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,  0, 0, 0,       0,  0, 0, 1, 0, 32'hC,        4'b0000, 0));
        tbl.push_back(mk(1, 1, 1, 1, 32'h0,        7,  1, 0, 32'h5,   1,  0, 0, 0, 0, 0,            4'b0000, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h0,        7,  1, 0, 32'h5,   1,  1, 0, 0, 0, 0,            4'b0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0,  0, 0, 0,       0,  0, 0, 1, 0, 32'h0,        4'b0001, 0));

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            reset_n    = !tbl[i].rst; rsp_ready = tbl[i].rr;
            req0_valid = tbl[i].v0; req0_op = tbl[i].op0; req0_data = tbl[i].d0; req0_shamt = tbl[i].s0;
            req1_valid = tbl[i].v1; req1_op = tbl[i].op1; req1_data = tbl[i].d1; req1_shamt = tbl[i].s1;
            @(negedge clk);
            chk($sformatf("vec%0d req0_ready", i), 32'(req0_ready), 32'(tbl[i].e_r0));
            chk($sformatf("vec%0d req1_ready", i), 32'(req1_ready), 32'(tbl[i].e_r1));
            chk($sformatf("vec%0d rsp_valid", i),  32'(rsp_valid),  32'(tbl[i].e_v));
            chk($sformatf("vec%0d rsp_id", i),     32'(rsp_id),     32'(tbl[i].e_id));
            chk($sformatf("vec%0d rsp_data", i),   rsp_data,        tbl[i].e_data);
            chk($sformatf("vec%0d rsp_flags", i),  32'(rsp_flags),  32'(tbl[i].e_flags));
            chk($sformatf("vec%0d rsp_err", i),    32'(rsp_err),    32'(tbl[i].e_err));
            @(posedge clk); #1;
        end

        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            do_rst = (c == 0) || ($urandom_range(0, 99) == 0);
            for (int q = 0; q < 2; q++) begin
                if (!pend[q] && $urandom_range(0, 9) < 6) begin
                    pend[q] = 1'b1;
                    p_op[q] = 2'($urandom_range(0, 3));
                    case ($urandom_range(0, 5))
                        0:       p_d[q] = 32'h0;
                        1:       p_d[q] = 32'h80000000;
                        default: p_d[q] = $urandom;
                    endcase
                    p_s[q] = 5'($urandom_range(0, 31));
                end
            end
            reset_n    = !do_rst;
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req0_valid = pend[0]; req0_op = p_op[0]; req0_data = p_d[0]; req0_shamt = p_s[0];
            req1_valid = pend[1]; req1_op = p_op[1]; req1_data = p_d[1]; req1_shamt = p_s[1];
            if (do_rst) begin
                m_full = 0; m_id = 0; m_err = 0; m_turn = 0;
                m_data = '0; m_flags = '0;
            end

            @(negedge clk);
            eg_any = 0; eg_idx = 0;
            if (!do_rst && (!m_full || rsp_ready) && (pend[0] || pend[1])) begin
                eg_any = 1;
                eg_idx = (pend[0] && pend[1]) ? m_turn : pend[1];
            end
            e_op = eg_any ? p_op[eg_idx] : 2'd0;
            e_t  = eg_any ? p_d[eg_idx]  : 32'd0;
            e_s  = eg_any ? p_s[eg_idx]  : 5'd0;
            chk("rnd req0_ready", 32'(req0_ready), 32'(eg_any && !eg_idx));
            chk("rnd req1_ready", 32'(req1_ready), 32'(eg_any && eg_idx));
            chk("rnd sh_op",      32'(sh_op),      32'(e_op));
            chk("rnd sh_T",       sh_T,            e_t);
            chk("rnd sh_shamt",   32'(sh_shamt),   32'(e_s));
            chk("rnd rsp_valid",  32'(rsp_valid),  32'(m_full));
            chk("rnd rsp_id",     32'(rsp_id),     32'(m_id));
            chk("rnd rsp_data",   rsp_data,        m_data);
            chk("rnd rsp_flags",  32'(rsp_flags),  32'(m_flags));
            chk("rnd rsp_err",    32'(rsp_err),    32'(m_err));

            @(posedge clk);
            if (eg_any) begin
                r       = ref_rsp(p_op[eg_idx], p_d[eg_idx], p_s[eg_idx]);
                m_full  = 1;
                m_id    = eg_idx;
                m_data  = r[31:0];
                m_flags = r[35:32];
                m_err   = (p_op[eg_idx] == 2'd3);
                m_turn  = !eg_idx;
                pend[eg_idx] = 1'b0;
            end else if (m_full && rsp_ready) begin
                m_full = 0;
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Sequencing and arbitration front-end for the shared 32-bit shift datapath (SLL/SRL/SRA barrel shifter) in the pipelined MIPS core. Two requesters (EX-stage shift ops and the multi-cycle mult/div helper) issue shift operations over valid/ready handshakes. The block grants one per cycle round-robin, drives the shared shifter's operand/amount/op lines, and captures result plus flags in a single-entry response register with backpressure.

## Interface
- DATA_W, 32, operand/result width (only 32 is supported)
- SHAMT_W, 5, shift-amount width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready = handshake)
- req0_op / req1_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
- req0_data / req1_data  in  DATA_W  operand T
- req0_shamt / req1_shamt  in  SHAMT_W  shift amount
- sh_op  out  2  op to shared shifter
- sh_T  out  DATA_W  operand to shifter
- sh_shamt  out  SHAMT_W  amount to shifter
- sh_Y  in  DATA_W  shifter result (combinational from sh_*)
- sh_flags  in  4  shifter {C,V,N,Z}
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester index of held result
- rsp_data  out  DATA_W  held result
- rsp_flags  out  4  held {C,V,N,Z}; V always 0
- rsp_err  out  1  held request used reserved op

## Operation
- Slot FSM, two states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- can_accept = EMPTY | (FULL & rsp_ready).
- Arbitration: last_grant register (1 bit). If both valid, grant ~last_grant; if one valid, grant it. Grant only when can_accept and reset_n=1. last_grant updates to granted index on each handshake only.
- reqN_ready = grant to N (combinational, at most one high). Non-granted ready = 0.
- sh_op/sh_T/sh_shamt = granted requester's fields; all zero when no grant.
- On handshake: rsp_data <= sh_Y, rsp_flags <= {sh_flags[3], 1'b0, sh_flags[1:0]}, rsp_id <= grant index, rsp_err <= (op==11), state -> FULL.
- Reserved op 11: sh_op driven 11; result/flags still captured from shifter; rsp_err=1.
- FULL & rsp_ready & no handshake -> EMPTY; rsp_data/flags/id/err hold last values.
- FULL & rsp_ready & handshake -> FULL with new contents (back-to-back).
- FULL & ~rsp_ready -> FULL, contents held, all reqN_ready = 0.
- Reset values: rsp_valid 0, rsp_data 0, rsp_flags 0, rsp_id 0, rsp_err 0, last_grant 1 (req0 wins first tie), req ready outputs 0 while reset_n low.
- Reset asserted mid-operation: held response discarded immediately (rsp_valid 0 asynchronously); no pending state survives.

## Timing
- Latency: handshake in cycle N -> rsp_valid=1 with result after edge ending N.
- Throughput: 1 op/cycle with rsp_ready held high.
- reqN_ready combinationally depends on reqN_valid, rsp_valid, rsp_ready, last_grant; requesters must not make valid depend on ready.
- Requester must hold valid and fields stable until handshake.
- Shifter path is combinational in the accept cycle; sh_Y sampled at the same edge.

## Test plan
- Single req0 SRA, data 0x80000000, shamt 4, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0xF8000000, rsp_id=0, N=1, Z=0, V=0, rsp_err=0.
- Both valid continuously, rsp_ready=1, 4 cycles -> grants 0,1,0,1 after reset; rsp_id sequence 0,1,0,1; one response per cycle.
- req1 SLL 0x00000001 shamt 31 accepted, rsp_ready=0 for 3 cycles with req0 valid -> rsp_data=0x80000000 held, req0_ready=0 throughout; rsp_ready=1 -> req0 granted same cycle, back-to-back response.
- req0 op 11, data 0x1234, shamt 0 -> rsp_err=1, rsp_id=0; next request op 00 -> rsp_err=0.
- reset_n low while FULL -> rsp_valid=0 immediately, all readies 0; after release, tie grants req0 first.
- SRL 0x00000000 shamt 7 -> rsp_data=0, Z=1, N=0, V=0.
